// File: rtl/adc_frame_pkg.sv
// Shared types and constants for the ADS131A0x SPI frame decoder.
// The READY/UNLOCK codes are exported for blocks that interpret status_word.
package adc_frame_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  localparam int SYNC_STAGES = 2;
  localparam int STATUS_BITS = 16;

  localparam logic [15:0] READY  = 16'hFF04;
  localparam logic [15:0] UNLOCK = 16'h0655;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-stage synchronizer for an asynchronous pin, plus registered one-cycle
// rise/fall pulses derived from the synchronized value and its previous sample.
module sync_edge_detect
  import adc_frame_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/adc_frame_deserializer.sv
// Passive decoder of ADS131A0x SPI frames: deserializes status + NUM_CH words
// per CS-low window and publishes sign-extended samples on a frame strobe.
module adc_frame_deserializer
  import adc_frame_pkg::*;
#(
  parameter int WORD_BITS  = 24,
  parameter int NUM_CH     = 4,
  parameter int DATA_BITS  = 24,
  parameter int COUNT_BITS = 16
) (
  input  logic                   system_clock,
  input  logic                   reset_n,
  input  logic                   spi_sclk,
  input  logic                   spi_cs,
  input  logic                   spi_miso,
  output logic [15:0]            status_word,
  output logic [NUM_CH*32-1:0]   ch_data,
  output logic                   frame_valid,
  output logic                   frame_error,
  output logic [COUNT_BITS-1:0]  frame_count,
  output logic                   busy
);

  localparam int BC_W = $clog2(WORD_BITS + 1);
  localparam int WC_W = $clog2(NUM_CH + 3);
  localparam logic [BC_W-1:0] BC_TOP  = BC_W'(WORD_BITS - 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(NUM_CH + 1);
  localparam logic [WC_W-1:0] WC_SAT  = WC_W'(NUM_CH + 2);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_fall, sclk_sync_unused, sclk_rise_unused;
  logic miso_s, miso_rise_unused, miso_fall_unused;

  sync_edge_detect #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk  (system_clock),
    .rst_n(reset_n),
    .din  (spi_cs),
    .sync (cs_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  sync_edge_detect #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk  (system_clock),
    .rst_n(reset_n),
    .din  (spi_sclk),
    .sync (sclk_sync_unused),
    .rise (sclk_rise_unused),
    .fall (sclk_fall)
  );

  sync_edge_detect #(.RESET_VAL(1'b0)) u_miso_sync (
    .clk  (system_clock),
    .rst_n(reset_n),
    .din  (spi_miso),
    .sync (miso_s),
    .rise (miso_rise_unused),
    .fall (miso_fall_unused)
  );

  state_t                  state_q, state_d;
  logic [1:0]              wait_cnt_q, wait_cnt_d;
  logic [BC_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]         word_cnt_q, word_cnt_d;
  logic [WORD_BITS-1:0]    shift_q, shift_d;
  logic [WORD_BITS-1:0]    stage_q [NUM_CH+1];
  logic [WORD_BITS-1:0]    stage_d [NUM_CH+1];
  logic [15:0]             status_q, status_d;
  logic [NUM_CH*32-1:0]    ch_q, ch_d;
  logic                    valid_q, valid_d;
  logic                    error_q, error_d;
  logic [COUNT_BITS-1:0]   count_q, count_d;

  logic [WORD_BITS-1:0]    shift_in;
  logic [15:0]             status_commit;
  logic [NUM_CH*32-1:0]    ch_commit;

  assign shift_in      = {shift_q[WORD_BITS-2:0], miso_s};
  assign status_commit = stage_q[0][WORD_BITS-1 -: STATUS_BITS];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
      assign ch_commit[gi*32 +: 32] = 32'($signed(stage_q[gi+1][WORD_BITS-1 -: DATA_BITS]));
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    shift_d    = shift_q;
    stage_d    = stage_q;
    status_d   = status_q;
    ch_d       = ch_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    count_d    = count_q;

    case (state_q)
      // The CS synchronizer holds its reset value for SYNC_STAGES cycles, so
      // CS must read high for one more cycle before it reflects the real pin.
      WAIT_IDLE: begin
        if (cs_s) begin
          if (wait_cnt_q == 2'(SYNC_STAGES)) state_d = IDLE;
          else wait_cnt_d = wait_cnt_q + 2'd1;
        end else begin
          wait_cnt_d = 2'd0;
        end
      end
      IDLE: begin
        if (cs_fall) begin
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          shift_d    = '0;
          state_d    = ACTIVE;
        end
      end
      ACTIVE: begin
        // CS rise takes priority; a coincident SCLK fall is dropped.
        if (cs_rise) begin
          state_d = IDLE;
          if (word_cnt_q == WC_LAST && bit_cnt_q == '0) begin
            status_d = status_commit;
            ch_d     = ch_commit;
            valid_d  = 1'b1;
            count_d  = count_q + COUNT_BITS'(1);
          end else begin
            error_d = 1'b1;
          end
        end else if (sclk_fall) begin
          shift_d = shift_in;
          if (bit_cnt_q == BC_TOP) begin
            bit_cnt_d = '0;
            for (int i = 0; i <= NUM_CH; i++) begin
              if (word_cnt_q == WC_W'(i)) stage_d[i] = shift_in;
            end
            if (word_cnt_q != WC_SAT) word_cnt_d = word_cnt_q + WC_W'(1);
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WAIT_IDLE;
      wait_cnt_q <= 2'd0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      shift_q    <= '0;
      for (int i = 0; i <= NUM_CH; i++) stage_q[i] <= '0;
      status_q   <= '0;
      ch_q       <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      shift_q    <= shift_d;
      stage_q    <= stage_d;
      status_q   <= status_d;
      ch_q       <= ch_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      count_q    <= count_d;
    end
  end

  assign status_word = status_q;
  assign ch_data     = ch_q;
  assign frame_valid = valid_q;
  assign frame_error = error_q;
  assign frame_count = count_q;
  assign busy        = (state_q == ACTIVE);

endmodule

// File: tb/tb_adc_frame_deserializer.sv
// Self-checking bench: drives SPI frames at ~4.167 MHz SCLK into three decoder
// instances (24/32/16-bit words) and compares against a frame-level model.
module tb_adc_frame_deserializer;

  localparam int HALF = 120;
  localparam int NCH  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sclk = 1'b0;
  logic cs = 1'b1;
  logic miso = 1'b0;

  logic [15:0]        status_a, status_w, status_h;
  logic [NCH*32-1:0]  ch_a, ch_w, ch_h;
  logic               valid_a, valid_w, valid_h;
  logic               err_a, err_w, err_h;
  logic [3:0]         count_a;
  logic [15:0]        count_w, count_h;
  logic               busy_a, busy_w, busy_h;

  always #10 clk = ~clk;

  adc_frame_deserializer #(.WORD_BITS(24), .NUM_CH(NCH), .DATA_BITS(24), .COUNT_BITS(4)) dut (
    .system_clock(clk), .reset_n(reset_n), .spi_sclk(sclk), .spi_cs(cs), .spi_miso(miso),
    .status_word(status_a), .ch_data(ch_a), .frame_valid(valid_a), .frame_error(err_a),
    .frame_count(count_a), .busy(busy_a));

  adc_frame_deserializer #(.WORD_BITS(32), .NUM_CH(NCH), .DATA_BITS(24), .COUNT_BITS(16)) dut_w (
    .system_clock(clk), .reset_n(reset_n), .spi_sclk(sclk), .spi_cs(cs), .spi_miso(miso),
    .status_word(status_w), .ch_data(ch_w), .frame_valid(valid_w), .frame_error(err_w),
    .frame_count(count_w), .busy(busy_w));

  adc_frame_deserializer #(.WORD_BITS(16), .NUM_CH(NCH), .DATA_BITS(16), .COUNT_BITS(16)) dut_h (
    .system_clock(clk), .reset_n(reset_n), .spi_sclk(sclk), .spi_cs(cs), .spi_miso(miso),
    .status_word(status_h), .ch_data(ch_h), .frame_valid(valid_h), .frame_error(err_h),
    .frame_count(count_h), .busy(busy_h));

  int checks = 0;
  int errors = 0;

  // Strobe monitor: pulse counts, pulse widths, CS-rise-to-strobe latency.
  int   cyc = 0, rise_cyc = 0, lat_a = 0;
  int   vcnt_a = 0, ecnt_a = 0, vwide_a = 0, ewide_a = 0, vcnt_w = 0, vcnt_h = 0;
  logic cs_last = 1'b1, v_prev = 1'b0, e_prev = 1'b0;
  logic busy_seen = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    cs_last <= cs;
    if (cs && !cs_last) rise_cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    v_prev <= valid_a;
    e_prev <= err_a;
    if (valid_a) begin
      vcnt_a <= vcnt_a + 1;
      if (!v_prev) lat_a <= cyc - rise_cyc;
      else vwide_a <= vwide_a + 1;
    end
    if (err_a) begin
      ecnt_a <= ecnt_a + 1;
      if (e_prev) ewide_a <= ewide_a + 1;
    end
    if (valid_w) vcnt_w <= vcnt_w + 1;
    if (valid_h) vcnt_h <= vcnt_h + 1;
  end

  // Frame-level reference model for the 24-bit instance.
  logic [15:0] m_status = '0;
  logic [31:0] m_ch [NCH] = '{default: '0};
  int          m_count = 0;
  bit          m_good;
  logic [31:0] fw [$];
  bit          tx [$];

  function automatic logic [31:0] chan_model(input longint word, input int wb, input int db);
    longint v;
    v = word >> (wb - db);
    if (v >= (longint'(1) << (db - 1))) v = v - (longint'(1) << db);
    return v[31:0];
  endfunction

  task automatic drive(input bit race, input int rst_at);
    cs = 1'b0;
    #(HALF);
    for (int i = 0; i < tx.size(); i++) begin
      miso = tx[i];
      sclk = 1'b1;
      #(HALF);
      if (i == 5) busy_seen = busy_a;
      if (race && i == tx.size() - 1) begin
        sclk = 1'b0;
        cs   = 1'b1;
      end else begin
        sclk = 1'b0;
        #(HALF);
      end
      if (i == rst_at) begin
        reset_n = 1'b0;
        #(100);
        reset_n = 1'b1;
      end
    end
    cs = 1'b1;
    #(HALF * 5);
  endtask

  task automatic frame24(input int extra, input bit race, input int rst_at);
    int nbits;
    tx.delete();
    foreach (fw[w]) for (int b = 23; b >= 0; b--) tx.push_back(fw[w][b]);
    for (int i = 0; i < extra; i++) tx.push_back(1'($urandom));
    nbits  = tx.size() - (race ? 1 : 0);
    m_good = (nbits == 24 * (NCH + 1)) && (rst_at < 0);
    drive(race, rst_at);
    if (rst_at >= 0) begin
      m_status = '0;
      for (int n = 0; n < NCH; n++) m_ch[n] = '0;
      m_count = 0;
    end else if (m_good) begin
      m_status = 16'(fw[0] >> 8);
      for (int n = 0; n < NCH; n++) m_ch[n] = chan_model(longint'(fw[n+1]), 24, 24);
      m_count = (m_count + 1) % 16;
    end
  endtask

  task automatic rand_words(input int n);
    fw.delete();
    for (int i = 0; i < n; i++) fw.push_back($urandom & 32'hFF_FFFF);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #(53);
    checks++; if (status_a !== 16'h0) begin errors++; $display("FAIL reset_status got=%h exp=0000", status_a); end
    checks++; if (ch_a !== '0) begin errors++; $display("FAIL reset_ch got=%h exp=0", ch_a); end
    checks++; if (valid_a !== 1'b0 || err_a !== 1'b0) begin errors++; $display("FAIL reset_strobes got=%b%b exp=00", valid_a, err_a); end
    checks++; if (count_a !== 4'h0 || count_w !== 16'h0 || count_h !== 16'h0) begin errors++; $display("FAIL reset_count got=%h/%h/%h exp=0", count_a, count_w, count_h); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    reset_n = 1'b1;
    #(200);
    $display("test_reset: outputs checked under reset");
  endtask

  task automatic test_good_frame();
    int v0, e0;
    logic [31:0] lit [NCH];
    lit = '{32'h007FFFFF, 32'hFF800000, 32'h00000001, 32'hFFFFFFFF};
    fw = {32'h224000, 32'h7FFFFF, 32'h800000, 32'h000001, 32'hFFFFFF};
    v0 = vcnt_a; e0 = ecnt_a;
    frame24(0, 1'b0, -1);
    checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL good_busy_mid got=%b exp=1", busy_seen); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL good_busy_after got=%b exp=0", busy_a); end
    checks++; if (vcnt_a - v0 != 1 || ecnt_a != e0) begin errors++; $display("FAIL good_strobes valid=%0d err=%0d exp=1,0", vcnt_a - v0, ecnt_a - e0); end
    checks++; if (lat_a != 3) begin errors++; $display("FAIL good_latency got=%0d exp=3", lat_a); end
    checks++; if (vwide_a != 0) begin errors++; $display("FAIL good_width extra_cycles=%0d exp=0", vwide_a); end
    checks++; if (status_a !== 16'h2240 || status_a !== m_status) begin errors++; $display("FAIL good_status got=%h exp=%h", status_a, m_status); end
    for (int n = 0; n < NCH; n++) begin
      checks++;
      if (ch_a[n*32 +: 32] !== lit[n] || ch_a[n*32 +: 32] !== m_ch[n]) begin
        errors++; $display("FAIL good_ch%0d got=%h exp=%h", n, ch_a[n*32 +: 32], lit[n]);
      end
    end
    checks++; if (count_a !== 4'(m_count) || count_a !== 4'd1) begin errors++; $display("FAIL good_count got=%0d exp=1", count_a); end
    $display("test_good_frame: status=%h count=%0d lat=%0d", status_a, count_a, lat_a);
  endtask

  task automatic test_short();
    int v0, e0;
    for (int c = 0; c < 2; c++) begin
      rand_words(c == 0 ? 3 : 4);
      v0 = vcnt_a; e0 = ecnt_a;
      frame24(c == 0 ? 0 : 10, 1'b0, -1);
      checks++; if (vcnt_a != v0 || ecnt_a - e0 != 1) begin errors++; $display("FAIL short%0d_strobes valid=%0d err=%0d exp=0,1", c, vcnt_a - v0, ecnt_a - e0); end
      checks++; if (status_a !== m_status || ch_a !== {m_ch[3], m_ch[2], m_ch[1], m_ch[0]}) begin errors++; $display("FAIL short%0d_hold status=%h ch=%h exp=%h", c, status_a, ch_a, m_status); end
      checks++; if (count_a !== 4'(m_count)) begin errors++; $display("FAIL short%0d_count got=%0d exp=%0d", c, count_a, m_count); end
      $display("test_short case %0d: err pulses=%0d count=%0d", c, ecnt_a - e0, count_a);
    end
    checks++; if (ewide_a != 0) begin errors++; $display("FAIL short_err_width extra_cycles=%0d exp=0", ewide_a); end
  endtask

  task automatic test_reset_mid();
    int v0, e0;
    rand_words(NCH + 1);
    v0 = vcnt_a; e0 = ecnt_a;
    frame24(0, 1'b0, 3 * 24 - 1);
    checks++; if (vcnt_a != v0 || ecnt_a != e0) begin errors++; $display("FAIL rstmid_strobes valid=%0d err=%0d exp=0,0", vcnt_a - v0, ecnt_a - e0); end
    checks++; if (count_a !== 4'd0 || status_a !== 16'h0) begin errors++; $display("FAIL rstmid_cleared count=%0d status=%h exp=0", count_a, status_a); end
    rand_words(NCH + 1);
    v0 = vcnt_a;
    frame24(0, 1'b0, -1);
    checks++; if (vcnt_a - v0 != 1 || count_a !== 4'd1) begin errors++; $display("FAIL rstmid_next valid=%0d count=%0d exp=1,1", vcnt_a - v0, count_a); end
    checks++; if (ch_a[63:32] !== m_ch[1]) begin errors++; $display("FAIL rstmid_ch1 got=%h exp=%h", ch_a[63:32], m_ch[1]); end
    $display("test_reset_mid: count=%0d", count_a);
  endtask

  task automatic test_race();
    int v0, e0;
    rand_words(NCH + 1);
    v0 = vcnt_a; e0 = ecnt_a;
    frame24(0, 1'b1, -1);
    checks++; if (vcnt_a != v0 || ecnt_a - e0 != 1) begin errors++; $display("FAIL race_strobes valid=%0d err=%0d exp=0,1", vcnt_a - v0, ecnt_a - e0); end
    checks++; if (count_a !== 4'(m_count)) begin errors++; $display("FAIL race_count got=%0d exp=%0d", count_a, m_count); end
    $display("test_race: err pulses=%0d", ecnt_a - e0);
  endtask

  task automatic test_back_to_back();
    int v0;
    reset_n = 1'b0;
    #(100);
    reset_n = 1'b1;
    m_status = '0; m_count = 0;
    for (int n = 0; n < NCH; n++) m_ch[n] = '0;
    #(200);
    for (int f = 0; f < 16; f++) begin
      rand_words(NCH + 1);
      v0 = vcnt_a;
      frame24(0, 1'b0, -1);
      checks++;
      if (vcnt_a - v0 != 1 || count_a !== 4'(m_count) || status_a !== m_status ||
          ch_a !== {m_ch[3], m_ch[2], m_ch[1], m_ch[0]}) begin
        errors++;
        $display("FAIL b2b_frame%0d valid=%0d count=%0d exp=%0d status=%h exp=%h ch=%h", f, vcnt_a - v0, count_a, m_count, status_a, m_status, ch_a);
      end
      $display("test_back_to_back frame %0d: count=%0d status=%h", f, count_a, status_a);
    end
    checks++; if (count_a !== 4'd0) begin errors++; $display("FAIL wrap_count got=%0d exp=0", count_a); end
  endtask

  task automatic test_word_sizes();
    logic [31:0] w32 [NCH+1];
    logic [15:0] w16 [NCH+1];
    int v0;
    for (int i = 0; i <= NCH; i++) begin w32[i] = $urandom; w16[i] = 16'($urandom); end
    w32[1] = 32'h80000000;
    w16[1] = 16'h8001;
    tx.delete();
    for (int i = 0; i <= NCH; i++) for (int b = 31; b >= 0; b--) tx.push_back(w32[i][b]);
    v0 = vcnt_w;
    drive(1'b0, -1);
    checks++; if (vcnt_w - v0 != 1) begin errors++; $display("FAIL w32_valid got=%0d exp=1", vcnt_w - v0); end
    checks++; if (ch_w[31:0] !== 32'hFF800000) begin errors++; $display("FAIL w32_ch0 got=%h exp=ff800000", ch_w[31:0]); end
    checks++; if (ch_w[63:32] !== chan_model(longint'(w32[2]), 32, 24)) begin errors++; $display("FAIL w32_ch1 got=%h exp=%h", ch_w[63:32], chan_model(longint'(w32[2]), 32, 24)); end
    checks++; if (status_w !== w32[0][31:16]) begin errors++; $display("FAIL w32_status got=%h exp=%h", status_w, w32[0][31:16]); end
    $display("test_word_sizes 32-bit: ch0=%h", ch_w[31:0]);
    tx.delete();
    for (int i = 0; i <= NCH; i++) for (int b = 15; b >= 0; b--) tx.push_back(w16[i][b]);
    v0 = vcnt_h;
    drive(1'b0, -1);
    checks++; if (vcnt_h - v0 != 1) begin errors++; $display("FAIL w16_valid got=%0d exp=1", vcnt_h - v0); end
    checks++; if (ch_h[31:0] !== 32'hFFFF8001) begin errors++; $display("FAIL w16_ch0 got=%h exp=ffff8001", ch_h[31:0]); end
    checks++; if (ch_h[127:96] !== chan_model(longint'(w16[4]), 16, 16)) begin errors++; $display("FAIL w16_ch3 got=%h exp=%h", ch_h[127:96], chan_model(longint'(w16[4]), 16, 16)); end
    checks++; if (status_h !== w16[0]) begin errors++; $display("FAIL w16_status got=%h exp=%h", status_h, w16[0]); end
    $display("test_word_sizes 16-bit: ch0=%h", ch_h[31:0]);
  endtask

  initial begin
    #(3);
    test_reset();
    test_good_frame();
    test_short();
    test_reset_mid();
    test_race();
    test_back_to_back();
    test_word_sizes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
